// File: rtl/alu_exec_unit_pkg.sv
// Shared control codes, opcode/flag encodings and FSM state type for the ALU execute stage.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_MUL = 4'd10;

    localparam logic [3:0] ALUOP_ARITH = 4'd8;
    localparam logic [3:0] ALUOP_SHIFT = 4'd9;
    localparam logic [3:0] ALUOP_MUL   = 4'd10;

    localparam logic [1:0] FLAG_ADD = 2'b01;
    localparam logic [1:0] FLAG_SUB = 2'b11;
    localparam logic [1:0] FLAG_SLL = 2'b00;
    localparam logic [1:0] FLAG_SRL = 2'b10;
    localparam logic [1:0] FLAG_SRA = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Signed overflow of a two's-complement add, given the operand and result sign bits.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_exec_unit_ctrl_decode.sv
// Combinational ALU-control decode: 4-bit opcode plus 2-bit function flag to 4-bit control code.
module alu_ctrl_decode (
    input  logic [3:0] alu_op,
    input  logic [1:0] flag,
    output logic [3:0] ctrl
);
    import alu_exec_unit_pkg::*;

    // Opcode/flag to control code; anything unrecognised falls back to OR.
    always_comb begin
        ctrl = ALU_OR;
        case (alu_op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: ctrl = {1'b0, alu_op[2:0]};
            ALUOP_ARITH: begin
                case (flag)
                    FLAG_ADD: ctrl = ALU_ADD;
                    FLAG_SUB: ctrl = ALU_SUB;
                    default:  ctrl = ALU_OR;
                endcase
            end
            ALUOP_SHIFT: begin
                case (flag)
                    FLAG_SLL: ctrl = ALU_SLL;
                    FLAG_SRL: ctrl = ALU_SRL;
                    FLAG_SRA: ctrl = ALU_SRA;
                    default:  ctrl = ALU_OR;
                endcase
            end
            ALUOP_MUL: ctrl = ALU_MUL;
            default:   ctrl = ALU_OR;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: one-cycle single ops, iterative multiply retiring MUL_STEP bits per cycle.
module alu_exec_unit #(
    parameter int WIDTH    = 16,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       flag,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_ctrl,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);
    import alu_exec_unit_pkg::*;

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH / MUL_STEP + 1);
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH / MUL_STEP);

    state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r, mcand_r, acc_nxt_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [3:0]         ctrl_s;
    logic               accept_s, mul_accept_s, mul_done_s, load_s;
    logic [WIDTH-1:0]   addend_s, alu_res_s, load_res_s;
    logic [WIDTH:0]     sum_s;
    logic [SHW-1:0]     shamt_s;
    logic               alu_carry_s, alu_ovf_s, load_ovf_s;
    logic [3:0]         load_ctrl_s;

    alu_ctrl_decode u_decode (
        .alu_op (alu_op),
        .flag   (flag),
        .ctrl   (ctrl_s)
    );

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        shamt_s     = op_b[SHW-1:0];
        addend_s    = (ctrl_s == ALU_SUB) ? ~op_b : op_b;
        sum_s       = {1'b0, op_a} + {1'b0, addend_s} + {{WIDTH{1'b0}}, (ctrl_s == ALU_SUB)};
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (ctrl_s)
            ALU_ADD, ALU_SUB: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = add_ovf(op_a[WIDTH-1], addend_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            ALU_AND: alu_res_s = op_a & op_b;
            ALU_XOR: alu_res_s = op_a ^ op_b;
            ALU_NOT: alu_res_s = ~op_a;
            ALU_SLL: alu_res_s = op_a << shamt_s;
            ALU_SRL: alu_res_s = op_a >> shamt_s;
            ALU_SRA: alu_res_s = WIDTH'($signed(op_a) >>> shamt_s);
            default: alu_res_s = op_a | op_b;
        endcase
    end

    // One multiply iteration: add the MUL_STEP partial products selected by the low multiplier bits.
    always_comb begin
        acc_nxt_s = acc_r;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_r[i]) begin
                acc_nxt_s = acc_nxt_s + (mcand_r << i);
            end else begin
                acc_nxt_s = acc_nxt_s;
            end
        end
    end

    assign accept_s     = (state_r == ST_IDLE) && in_valid && in_ready;
    assign mul_accept_s = accept_s && (ctrl_s == ALU_MUL);
    assign mul_done_s   = (state_r == ST_MUL) && (cnt_r == CNT_W'(1)) && !flush;
    assign load_s       = (accept_s && !mul_accept_s) || mul_done_s;

    // Output-register load mux: multiply completion takes the accumulator, otherwise the ALU result.
    always_comb begin
        if (mul_done_s) begin
            load_res_s  = acc_nxt_s[WIDTH-1:0];
            load_ctrl_s = ALU_MUL;
            load_ovf_s  = |acc_nxt_s[2*WIDTH-1:WIDTH];
        end else begin
            load_res_s  = alu_res_s;
            load_ctrl_s = ctrl_s;
            load_ovf_s  = alu_ovf_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // FSM next state; flush always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_accept_s) state_nxt_s = ST_MUL;
                else              state_nxt_s = ST_IDLE;
            end
            ST_MUL: begin
                if (flush || (cnt_r == CNT_W'(1))) state_nxt_s = ST_IDLE;
                else                               state_nxt_s = ST_MUL;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE with a free (or draining) output slot and no flush.
    always_comb begin
        if ((state_r == ST_IDLE) && (!out_valid || out_ready) && !flush) in_ready = 1'b1;
        else                                                             in_ready = 1'b0;
    end

    // Iterative multiplier operands, accumulator and remaining-step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (flush) begin
            cnt_r <= '0;
        end else if (mul_accept_s) begin
            cnt_r    <= MUL_CYCLES;
            acc_r    <= '0;
            mcand_r  <= {{WIDTH{1'b0}}, op_a};
            mplier_r <= op_b;
        end else if (state_r == ST_MUL) begin
            cnt_r    <= cnt_r - CNT_W'(1);
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << MUL_STEP;
            mplier_r <= mplier_r >> MUL_STEP;
        end
    end

    // Output register: held under backpressure, dropped on consume or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ctrl   <= 4'd0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_s) begin
            out_valid  <= 1'b1;
            out_result <= load_res_s;
            out_ctrl   <= load_ctrl_s;
            out_zero   <= (load_res_s == '0);
            out_carry  <= mul_done_s ? 1'b0 : alu_carry_s;
            out_ovf    <= load_ovf_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
